ps2_key_event: RTL
==================

Name: ps2_key_event

Overview:
- Sits between the PS/2 byte receiver and the game logic.
- Turns raw scancode bytes into clean key events: tracks prefixes, suppresses typematic repeats and translates the code to ASCII.
- Queues press events in a small FIFO with a valid/ready handshake, and also exposes the held-key level.
- Removes the need for "pressing" edge-detection latches in the top level; each physical press is delivered to the game exactly once.

Parameters:
- FIFO_DEPTH, 4, event queue entries; power of two, 2..16.
- TIMEOUT_CYC, 50000, clk cycles allowed between a prefix byte (E0/F0) and the byte that follows it before the decoder abandons the sequence.
- REPEAT_EN, 0, 1 = each typematic repeat of a held key is queued as a new press event.

Ports:
- clk  in  1  system clock (CLOCK_50 domain)
- rst_n  in  1  asynchronous active-low reset
- byte_valid  in  1  one-cycle strobe: byte_data holds a new scancode byte
- byte_data  in  8  scancode byte from the PS/2 receiver
- evt_valid  out  1  FIFO not empty
- evt_ready  in  1  consumer pops the head entry when evt_valid && evt_ready
- evt_ascii  out  8  ASCII code of the head entry
- evt_ext  out  1  head entry was an E0-prefixed key
- key_down  out  1  a mapped key is currently held
- key_ascii  out  8  ASCII of the held key; 0x00 when none is held
- overflow  out  1  sticky: an event was dropped because the FIFO was full
- overflow_clr  in  1  clears overflow

Behaviour:
- Reset (asynchronous, rst_n=0):
  - FIFO empty; evt_valid=0, evt_ascii=0x00, evt_ext=0.
  - key_down=0, key_ascii=0x00, overflow=0.
  - Decoder state IDLE, timeout counter 0.
  - Asserting reset mid-sequence or mid-pop discards everything.
- Decoder FSM, advancing only on byte_valid:
  - IDLE: E0 -> EXT; F0 -> BRK; any other byte -> MAKE action, stay IDLE.
  - EXT: F0 -> EXT_BRK; E0 -> stay EXT; any other byte -> MAKE action with ext=1, go IDLE.
  - BRK: E0/F0 -> IDLE with no action (malformed sequence); any other byte -> BREAK action, go IDLE.
  - EXT_BRK: any non-prefix byte -> BREAK action with ext=1, go IDLE.
  - In EXT, BRK and EXT_BRK the counter increments each cycle without byte_valid. When it reaches TIMEOUT_CYC-1 the FSM returns to IDLE with no action. The counter clears on every byte_valid.
- Translation (combinational):
  - Letters: set-2 codes for a..z map to lowercase 0x61..0x7A.
  - Digits: 0x45, 0x16, 0x1E, 0x26, 0x25, 0x2E, 0x36, 0x3D, 0x3E, 0x46 map to '0'..'9'.
  - 0x5A -> 0x0D (Enter); 0x29 -> 0x20 (space).
  - E0-prefixed codes map to 0x00, except E0 5A -> 0x0D.
  - Every other code -> 0x00 (unmapped).
- MAKE action (mapped code only; unmapped codes are ignored entirely):
  - If key_down=1 and the code equals the held code (typematic repeat): no push unless REPEAT_EN=1.
  - Otherwise: push {ascii, ext}; key_down=1; key_ascii=ascii; store the code as the held code. A new key overrides the held one.
- BREAK action:
  - If the code and ext match the held code: key_down=0, key_ascii=0x00.
  - Breaks of any other key are ignored.
- Timing:
  - key_down and key_ascii update on the clk edge following the byte_valid that completes the sequence.
  - The event is visible on evt_valid on that same edge, i.e. 1-cycle latency from the final byte.
- FIFO:
  - Show-ahead: evt_ascii and evt_ext always reflect the head entry; they are undefined-but-stable when empty, and are driven 0 after reset.
  - Push while full: the event is dropped and overflow is set to 1, including when a pop happens in the same cycle.
  - Push and pop in the same cycle while not full: both occur and the count is unchanged.
  - Pop while empty: ignored.
  - Pointers wrap modulo FIFO_DEPTH; count width is clog2(FIFO_DEPTH)+1.
- overflow_clr:
  - Clears overflow.
  - If overflow_clr and a dropping push occur in the same cycle, overflow stays 1.

Decomposition:
- Shared package ps2_pkg holds:
  - Byte constants: SC_EXT=8'hE0, SC_BRK=8'hF0, SC_ENTER=8'h5A, SC_SPACE=8'h29.
  - FSM state encoding (IDLE, EXT, BRK, EXT_BRK, 2 bits).
  - ASCII constants: ASC_NONE=8'h00, ASC_CR=8'h0D.
- One sub-module: ps2_scan_to_ascii, a combinational lookup with inputs (code[7:0], ext) and output ascii[7:0]. The FIFO stays inline.

Test Plan:
- Press/release: bytes 1C, F0, 1C with evt_ready=0 -> one event 0x61; key_down goes 1 then 0; key_ascii goes 0x61 then 0x00.
- Typematic repeat: 1C, 1C, 1C, F0, 1C with REPEAT_EN=0 -> exactly one event 0x61. The same sequence with REPEAT_EN=1 -> three events.
- Extended key: E0, 5A, E0, F0, 5A -> one event 0x0D with evt_ext=1; key_down returns to 0.
- Overflow: five distinct makes (1C, 32, 21, 23, 24) with evt_ready=0 and FIFO_DEPTH=4 -> four events 0x61, 0x62, 0x63, 0x64, then overflow=1. Pulsing overflow_clr -> overflow=0. Popping returns the events in order.
- Prefix timeout: F0, then idle for TIMEOUT_CYC cycles, then 1C -> treated as a make, giving one event 0x61. Unmapped make 0x05 (F1) -> no event, key_down stays 0.
- Reset mid-sequence: E0, then rst_n low for 1 cycle, then 5A -> event 0x0D with evt_ext=0 (E0 forgotten); FIFO emptied by the reset.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants and FSM encoding for the PS/2 key event path.
package ps2_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_SPACE = 8'h29;

    localparam logic [7:0] ASC_NONE  = 8'h00;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_SPACE = 8'h20;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } ps2_state_e;

endpackage

// File: rtl/ps2_scan_to_ascii.sv
// Combinational set-2 scancode to ASCII lookup; unmapped codes yield ASC_NONE.
module ps2_scan_to_ascii
    import ps2_pkg::*;
(
    input  logic [7:0] code,
    input  logic       ext,
    output logic [7:0] ascii
);

    // Table lookup; only E0 5A is meaningful among extended codes
    always_comb begin
        ascii = ASC_NONE;
        if (ext) begin
            if (code == SC_ENTER) begin
                ascii = ASC_CR;
            end else begin
                ascii = ASC_NONE;
            end
        end else begin
            case (code)
                8'h1C: ascii = 8'h61; 8'h32: ascii = 8'h62; 8'h21: ascii = 8'h63;
                8'h23: ascii = 8'h64; 8'h24: ascii = 8'h65; 8'h2B: ascii = 8'h66;
                8'h34: ascii = 8'h67; 8'h33: ascii = 8'h68; 8'h43: ascii = 8'h69;
                8'h3B: ascii = 8'h6A; 8'h42: ascii = 8'h6B; 8'h4B: ascii = 8'h6C;
                8'h3A: ascii = 8'h6D; 8'h31: ascii = 8'h6E; 8'h44: ascii = 8'h6F;
                8'h4D: ascii = 8'h70; 8'h15: ascii = 8'h71; 8'h2D: ascii = 8'h72;
                8'h1B: ascii = 8'h73; 8'h2C: ascii = 8'h74; 8'h3C: ascii = 8'h75;
                8'h2A: ascii = 8'h76; 8'h1D: ascii = 8'h77; 8'h22: ascii = 8'h78;
                8'h35: ascii = 8'h79; 8'h1A: ascii = 8'h7A;
                8'h45: ascii = 8'h30; 8'h16: ascii = 8'h31; 8'h1E: ascii = 8'h32;
                8'h26: ascii = 8'h33; 8'h25: ascii = 8'h34; 8'h2E: ascii = 8'h35;
                8'h36: ascii = 8'h36; 8'h3D: ascii = 8'h37; 8'h3E: ascii = 8'h38;
                8'h46: ascii = 8'h39;
                SC_ENTER: ascii = ASC_CR;
                SC_SPACE: ascii = ASC_SPACE;
                default:  ascii = ASC_NONE;
            endcase
        end
    end

endmodule

// File: rtl/ps2_key_event.sv
// Scancode byte stream to de-duplicated key press events, with an event FIFO
// and the currently held key exposed as a level.
module ps2_key_event
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 50000,
    parameter bit REPEAT_EN   = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_ascii,
    output logic       evt_ext,
    output logic       key_down,
    output logic [7:0] key_ascii,
    output logic       overflow,
    input  logic       overflow_clr
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    ps2_state_e       state_r;
    logic [TMO_W-1:0] tmo_cnt_r;
    logic [7:0]       held_code_r;
    logic             held_ext_r;
    logic             key_down_r;
    logic [7:0]       key_ascii_r;
    logic [8:0]       mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             overflow_r;

    logic       lut_ext_s;
    logic [7:0] ascii_s;
    logic       is_prefix_s;
    logic       make_s;
    logic       brk_s;
    logic       match_s;
    logic       new_key_s;
    logic       repeat_s;
    logic       release_s;
    logic       push_s;
    logic       full_s;
    logic       pop_s;
    logic       push_ok_s;
    logic       drop_s;

    assign lut_ext_s = (state_r == EXT) || (state_r == EXT_BRK);

    ps2_scan_to_ascii u_lut (
        .code  (byte_data),
        .ext   (lut_ext_s),
        .ascii (ascii_s)
    );

    // Decode which action the current byte completes, if any
    always_comb begin
        make_s = 1'b0;
        brk_s  = 1'b0;
        is_prefix_s = (byte_data == SC_EXT) || (byte_data == SC_BRK);
        case (state_r)
            IDLE:    make_s = byte_valid && !is_prefix_s;
            EXT:     make_s = byte_valid && !is_prefix_s;
            BRK:     brk_s  = byte_valid && !is_prefix_s;
            EXT_BRK: brk_s  = byte_valid && !is_prefix_s;
            default: begin
                make_s = 1'b0;
                brk_s  = 1'b0;
            end
        endcase
    end

    assign match_s   = key_down_r && (held_code_r == byte_data) && (held_ext_r == lut_ext_s);
    assign new_key_s = make_s && (ascii_s != ASC_NONE) && !match_s;
    assign repeat_s  = make_s && (ascii_s != ASC_NONE) && match_s;
    assign release_s = brk_s && match_s;
    assign push_s    = new_key_s || (REPEAT_EN && repeat_s);
    assign full_s    = (count_r == DEPTH_C);
    assign pop_s     = (count_r != '0) && evt_ready;
    assign push_ok_s = push_s && !full_s;
    assign drop_s    = push_s && full_s;

    // Prefix FSM with abandon timeout, plus the held-key level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            tmo_cnt_r   <= '0;
            held_code_r <= 8'h00;
            held_ext_r  <= 1'b0;
            key_down_r  <= 1'b0;
            key_ascii_r <= ASC_NONE;
        end else begin
            if (byte_valid) begin
                tmo_cnt_r <= '0;
                case (state_r)
                    IDLE: begin
                        if (byte_data == SC_EXT)      state_r <= EXT;
                        else if (byte_data == SC_BRK) state_r <= BRK;
                        else                          state_r <= IDLE;
                    end
                    EXT: begin
                        if (byte_data == SC_BRK)      state_r <= EXT_BRK;
                        else if (byte_data == SC_EXT) state_r <= EXT;
                        else                          state_r <= IDLE;
                    end
                    BRK:     state_r <= IDLE;
                    EXT_BRK: state_r <= IDLE;
                    default: state_r <= IDLE;
                endcase
            end else if (state_r != IDLE) begin
                if (tmo_cnt_r == TMO_LAST) begin
                    state_r   <= IDLE;
                    tmo_cnt_r <= '0;
                end else begin
                    tmo_cnt_r <= tmo_cnt_r + TMO_W'(1'b1);
                end
            end else begin
                tmo_cnt_r <= '0;
            end

            if (new_key_s) begin
                key_down_r  <= 1'b1;
                key_ascii_r <= ascii_s;
                held_code_r <= byte_data;
                held_ext_r  <= lut_ext_s;
            end else if (release_s) begin
                key_down_r  <= 1'b0;
                key_ascii_r <= ASC_NONE;
            end else begin
                key_down_r  <= key_down_r;
            end
        end
    end

    // Show-ahead event FIFO; a push into a full queue is lost and flagged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 9'h000;
            end
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= {ascii_s, lut_ext_s};
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            if (push_ok_s && !pop_s) begin
                count_r <= count_r + CNT_W'(1'b1);
            end else if (!push_ok_s && pop_s) begin
                count_r <= count_r - CNT_W'(1'b1);
            end else begin
                count_r <= count_r;
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (overflow_clr) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    assign evt_valid = (count_r != '0);
    assign evt_ascii = mem_r[rd_ptr_r][8:1];
    assign evt_ext   = mem_r[rd_ptr_r][0];
    assign key_down  = key_down_r;
    assign key_ascii = key_ascii_r;
    assign overflow  = overflow_r;

endmodule
